// File: rtl/seq_mult_sa.sv
// Sequential shift-add multiplier: one partial-product add/shift per clock, WIDTH+1 edges from start to done.
// Optional two's-complement mode is enabled by defining SEQ_MULT_SA_SIGNED_EN (adds the sgn input).
module seq_mult_sa #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
`ifdef SEQ_MULT_SA_SIGNED_EN
  input  logic               sgn,
`endif
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] p,
  output logic [1:0]         o_state
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_m;
  logic [WIDTH-1:0] r_h;
  logic [WIDTH-1:0] r_l;
  logic [CW-1:0]    r_cnt;
  logic             r_neg;

  logic             w_neg_a;
  logic             w_neg_b;
  logic [WIDTH-1:0] w_a_mag;
  logic [WIDTH-1:0] w_b_mag;
  logic [WIDTH:0]   w_sum;
  logic [2*WIDTH-1:0] w_prod_neg;

  // Signed operands are reduced to magnitudes at load; the product is
  // negated in the final RUN cycle, so both modes share one latency.
`ifdef SEQ_MULT_SA_SIGNED_EN
  assign w_neg_a = sgn & a[WIDTH-1];
  assign w_neg_b = sgn & b[WIDTH-1];
`else
  assign w_neg_a = 1'b0;
  assign w_neg_b = 1'b0;
`endif

  assign w_a_mag    = w_neg_a ? (~a + WIDTH'(1)) : a;
  assign w_b_mag    = w_neg_b ? (~b + WIDTH'(1)) : b;
  assign w_sum      = {1'b0, r_h} + (r_l[0] ? {1'b0, r_m} : '0);
  assign w_prod_neg = ~{r_h, r_l} + (2*WIDTH)'(1);

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_m     <= '0;
      r_h     <= '0;
      r_l     <= '0;
      r_cnt   <= '0;
      r_neg   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          r_done <= 1'b0;
          if (start) begin
            r_m     <= w_a_mag;
            r_h     <= '0;
            r_l     <= w_b_mag;
            r_cnt   <= '0;
            r_neg   <= w_neg_a ^ w_neg_b;
            r_state <= S_RUN;
            r_busy  <= 1'b1;
          end else begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        end
        S_RUN: begin
          // After WIDTH iterations one extra cycle applies the sign and hands off to DONE.
          if (r_cnt == CW'(WIDTH)) begin
            if (r_neg) begin
              {r_h, r_l} <= w_prod_neg;
            end
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else begin
            r_h   <= w_sum[WIDTH:1];
            r_l   <= {w_sum[0], r_l[WIDTH-1:1]};
            r_cnt <= r_cnt + CW'(1);
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign busy    = r_busy;
  assign done    = r_done;
  assign p       = {r_h, r_l};
  assign o_state = r_state;

endmodule

// File: tb/tb_seq_mult_sa.sv
// Directed bench for seq_mult_sa at WIDTH=8: latency, hold, ignored start, abort, back-to-back,
// plus signed-mode vectors when SEQ_MULT_SA_SIGNED_EN is defined.
module tb_seq_mult_sa;

  localparam int W = 8;

  logic           clk;
  logic           reset;
  logic           start;
  logic           sgn;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic           busy;
  logic           done;
  logic [2*W-1:0] p;
  logic [1:0]     o_state;

  logic [2*W-1:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  seq_mult_sa #(.WIDTH(W)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
`ifdef SEQ_MULT_SA_SIGNED_EN
    .sgn     (sgn),
`endif
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .p       (p),
    .o_state (o_state)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic start_op(input logic [W-1:0] av, input logic [W-1:0] bv,
                          input logic sv, input logic [2*W-1:0] exp_p);
    start = 1'b1;
    a     = av;
    b     = bv;
    sgn   = sv;
    exp_q.push_back(exp_p);
    tick();
    start = 1'b0;
    a     = $urandom_range(255, 0);
    b     = $urandom_range(255, 0);
  endtask

  task automatic wait_done(input string tag, input int exp_lat, output int busy_cnt);
    int lat;
    bit seen;
    logic [2*W-1:0] e;
    lat = 0;
    seen = 0;
    busy_cnt = 0;
    while (!seen && lat < 40) begin
      tick();
      lat++;
      if (done === 1'b1) seen = 1;
      else if (busy === 1'b1) busy_cnt++;
    end
    check({tag, " done seen"}, 32'(seen), 32'd1);
    check({tag, " latency"}, 32'(lat), 32'(exp_lat));
    if (exp_q.size() > 0) e = exp_q.pop_front();
    else e = '1;
    check({tag, " p"}, 32'(p), 32'(e));
    check({tag, " busy at done"}, 32'(busy), 32'd0);
  endtask

  task automatic watch_quiet(input string tag, input int cycles, input logic [2*W-1:0] exp_p);
    int n_done;
    int n_pchg;
    n_done = 0;
    n_pchg = 0;
    for (int i = 0; i < cycles; i++) begin
      tick();
      if (done !== 1'b0) n_done++;
      if (p !== exp_p) n_pchg++;
    end
    check({tag, " no extra done"}, 32'(n_done), 32'd0);
    check({tag, " p held"}, 32'(n_pchg), 32'd0);
  endtask

  initial begin
    int bc;
    reset = 1'b0;
    start = 1'b0;
    sgn   = 1'b0;
    a     = '0;
    b     = '0;

    // reset then idle
    tick();
    tick();
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset p", 32'(p), 32'h0000);
    check("reset state", 32'(o_state), 32'd0);
    reset = 1'b1;
    tick();

    // basic multiply: 255*255
    start_op(8'd255, 8'd255, 1'b0, 16'hFE01);
    check("basic busy after start", 32'(busy), 32'd1);
    wait_done("basic", W + 1, bc);
    check("basic busy cycles after start edge", 32'(bc), 32'(W));
    tick();
    check("basic done pulse width", 32'(done), 32'd0);
    watch_quiet("basic hold", 20, 16'hFE01);

    // zero and identity
    start_op(8'd0, 8'd173, 1'b0, 16'h0000);
    wait_done("zero", W + 1, bc);
    start_op(8'd1, 8'd173, 1'b0, 16'h00AD);
    wait_done("identity", W + 1, bc);
    start_op(8'h80, 8'h80, 1'b0, 16'h4000);
    wait_done("u 80x80", W + 1, bc);
    start_op(8'hFD, 8'h05, 1'b0, 16'h04F1);
    wait_done("u FDx05", W + 1, bc);
    tick();

    // ignored start at edge 3
    start_op(8'd3, 8'd4, 1'b0, 16'h000C);
    tick();
    tick();
    start = 1'b1;
    a     = 8'd100;
    b     = 8'd100;
    tick();
    start = 1'b0;
    check("ignored start busy", 32'(busy), 32'd1);
    wait_done("ignored", W + 1 - 3, bc);
    watch_quiet("ignored after", 15, 16'h000C);

    // reset mid-operation
    start_op(8'd7, 8'd9, 1'b0, 16'h003F);
    void'(exp_q.pop_back());
    tick();
    tick();
    tick();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    check("abort p", 32'(p), 32'h0000);
    check("abort busy", 32'(busy), 32'd0);
    check("abort state", 32'(o_state), 32'd0);
    watch_quiet("abort after", 15, 16'h0000);

    // back-to-back: start held through the DONE cycle
    start_op(8'd7, 8'd9, 1'b0, 16'h003F);
    wait_done("b2b first", W + 1, bc);
    start_op(8'd2, 8'd3, 1'b0, 16'h0006);
    wait_done("b2b second", W + 1, bc);
    tick();

`ifdef SEQ_MULT_SA_SIGNED_EN
    start_op(8'hFD, 8'h05, 1'b1, 16'hFFF1);
    wait_done("s FDx05", W + 1, bc);
    start_op(8'h80, 8'h80, 1'b1, 16'h4000);
    wait_done("s 80x80", W + 1, bc);
    start_op(8'h80, 8'h80, 1'b0, 16'h4000);
    wait_done("s0 80x80", W + 1, bc);
    start_op(8'hFF, 8'hFF, 1'b0, 16'hFE01);
    wait_done("s0 FFxFF", W + 1, bc);
    start_op(8'hFF, 8'hFF, 1'b1, 16'h0001);
    wait_done("s FFxFF", W + 1, bc);
    start_op(8'h05, 8'hF9, 1'b1, 16'hFFDD);
    wait_done("s 05xF9", W + 1, bc);
    tick();
`endif

    check("scoreboard drained", 32'(exp_q.size()), 32'd0);

    // final report
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
